// File: rtl/ift_sram_mem_pipe.sv
// Multi-taint pipelined SRAM model with conservative information-flow tracking and a taint-clear sweep.
// Optional per-channel tainted-address event counters are enabled by defining IFT_SRAM_TAINT_STATS_EN.
module ift_sram_mem_pipe #(
   parameter int unsigned Width       = 32,
   parameter int unsigned Depth       = 1024,
   parameter int unsigned NumTaints   = 2,
   parameter int unsigned ReadLatency = 1,
   localparam int unsigned AddrW      = $clog2(Depth)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                req_i,
   output logic                                gnt_o,
   input  logic                                write_i,
   input  logic [AddrW-1:0]                    addr_i,
   input  logic [Width-1:0]                    wdata_i,
   input  logic [Width-1:0]                    wmask_i,
   output logic                                rvalid_o,
   output logic [Width-1:0]                    rdata_o,
   input  logic [NumTaints-1:0]                req_i_taint,
   input  logic [NumTaints-1:0]                write_i_taint,
   input  logic [NumTaints-1:0][AddrW-1:0]     addr_i_taint,
   input  logic [NumTaints-1:0][Width-1:0]     wdata_i_taint,
   input  logic [NumTaints-1:0][Width-1:0]     wmask_i_taint,
   output logic [NumTaints-1:0][Width-1:0]     rdata_o_taint,
   input  logic                                clr_req_i,
   output logic                                clr_busy_o,
   output logic [NumTaints-1:0]                full_taint_o
`ifdef IFT_SRAM_TAINT_STATS_EN
   ,
   output logic [NumTaints-1:0][15:0]          taint_evt_cnt_o
`endif
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SWEEP = 1'b1;

   logic                   state_q;
   logic [AddrW-1:0]       sweep_addr_q;
   logic                   idle;
   logic                   sweep_start;
   logic                   accept;
   logic                   wr_fire;
   logic                   rd_fire;
   logic [NumTaints-1:0]   ctrl_taint;
   logic [NumTaints-1:0]   full_set;
   logic [NumTaints-1:0]   full_nxt;

   logic [Width-1:0]       mem_data  [Depth];
   logic [Width-1:0]       mem_taint [NumTaints][Depth];

   logic [ReadLatency-1:0]                 pipe_vld;
   logic [Width-1:0]                       pipe_data  [ReadLatency];
   logic [NumTaints-1:0][Width-1:0]        pipe_taint [ReadLatency];

   assign idle        = (state_q == ST_IDLE);
   assign gnt_o       = req_i & idle;
   assign clr_busy_o  = ~idle;
   assign sweep_start = idle & clr_req_i;
   assign accept      = gnt_o & ~rst_i;
   assign wr_fire     = accept & write_i;
   assign rd_fire     = accept & ~write_i;

   // full_nxt is the flag value after this edge; reads in flight pick it up at every stage.
   always_comb begin
      ctrl_taint = '0;
      full_set   = '0;
      full_nxt   = '0;
      for (int t = 0; t < NumTaints; t++) begin
         ctrl_taint[t] = (|addr_i_taint[t]) | req_i_taint[t] | write_i_taint[t];
         full_set[t]   = (req_i | req_i_taint[t]) & (write_i | write_i_taint[t]) &
                         (|addr_i_taint[t]) & (|(wmask_i | wmask_i_taint[t]));
         full_nxt[t]   = sweep_start ? 1'b0 : (full_taint_o[t] | full_set[t]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_SWEEP;
         sweep_addr_q <= '0;
         full_taint_o <= '0;
      end else begin
         full_taint_o <= full_nxt;
         case (state_q)
            ST_IDLE: begin
               if (clr_req_i) begin
                  state_q      <= ST_SWEEP;
                  sweep_addr_q <= '0;
               end
            end
            default: begin
               sweep_addr_q <= sweep_addr_q + AddrW'(1);
               if (sweep_addr_q == AddrW'(Depth - 1)) state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // NOTE: storage arrays have no reset; data survives reset and taint is cleared by the sweep.
   always_ff @(posedge clk_i) begin
      if (wr_fire) mem_data[addr_i] <= (mem_data[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
   end

   always_ff @(posedge clk_i) begin
      for (int t = 0; t < NumTaints; t++) begin
         if (wr_fire) begin
            mem_taint[t][addr_i] <= (wmask_i & (wdata_i_taint[t] | wmask_i_taint[t])) |
                                    (~wmask_i & (mem_taint[t][addr_i] | wmask_i_taint[t]));
         end else if (!idle && !rst_i) begin
            mem_taint[t][sweep_addr_q] <= '0;
         end
      end
   end

   // Each stage only loads on a valid read, so the last stage holds its value between reads.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_vld <= '0;
         for (int i = 0; i < ReadLatency; i++) begin
            pipe_data[i]  <= '0;
            pipe_taint[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= rd_fire;
         if (rd_fire) begin
            pipe_data[0] <= mem_data[addr_i];
            for (int t = 0; t < NumTaints; t++) begin
               pipe_taint[0][t] <= mem_taint[t][addr_i] | {Width{ctrl_taint[t] | full_nxt[t]}};
            end
         end
         for (int i = 1; i < ReadLatency; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            if (pipe_vld[i-1]) begin
               pipe_data[i] <= pipe_data[i-1];
               for (int t = 0; t < NumTaints; t++) begin
                  pipe_taint[i][t] <= pipe_taint[i-1][t] | {Width{full_nxt[t]}};
               end
            end
         end
      end
   end

   assign rvalid_o      = pipe_vld[ReadLatency-1];
   assign rdata_o       = pipe_data[ReadLatency-1];
   assign rdata_o_taint = pipe_taint[ReadLatency-1];

`ifdef IFT_SRAM_TAINT_STATS_EN
   logic [NumTaints-1:0][15:0] evt_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || sweep_start) begin
         evt_cnt_q <= '0;
      end else begin
         for (int t = 0; t < NumTaints; t++) begin
            if (accept && (|addr_i_taint[t]) && (evt_cnt_q[t] != 16'hFFFF)) begin
               evt_cnt_q[t] <= evt_cnt_q[t] + 16'd1;
            end
         end
      end
   end

   assign taint_evt_cnt_o = evt_cnt_q;
`endif

endmodule
